// File: rtl/line_buffer_pkg.sv
// Shared types and sizing helpers for the Sobel row-delay line buffer controller.
package line_buffer_pkg;

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        RUN   = 2'd2
    } state_e;

    function automatic int x_width(input int line_width);
        return (line_width > 1) ? $clog2(line_width) : 1;
    endfunction

    function automatic int y_width(input int line_height);
        return (line_height > 1) ? $clog2(line_height) : 1;
    endfunction

endpackage

// File: rtl/async_ram_1r1w.sv
// Simple dual-port RAM: one write port, one registered read port, each on its own clock.
module async_ram_1r1w #(
    parameter int WIDTH_P  = 8,
    parameter int DEPTH_P  = 640,
    parameter int ADDR_W_P = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1
) (
    input  logic                wr_clk_i,
    input  logic                wr_rstn_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W_P-1:0] wr_addr_i,
    input  logic [WIDTH_P-1:0]  wr_data_i,
    input  logic                rd_clk_i,
    input  logic                rd_rstn_i,
    input  logic                rd_en_i,
    input  logic [ADDR_W_P-1:0] rd_addr_i,
    output logic [WIDTH_P-1:0]  rd_data_o
);

    logic [WIDTH_P-1:0] mem [DEPTH_P];

    // Writes are suppressed while the write domain is held in reset.
    always_ff @(posedge wr_clk_i) begin
        if (wr_en_i && wr_rstn_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge rd_clk_i or negedge rd_rstn_i) begin
        if (!rd_rstn_i) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Row-delay line buffer controller: emits {row y-2, row y-1, row y} columns per input pixel.
// state | meaning
// FILL0 | accepting row 0, no output
// FILL1 | accepting row 1, no output
// RUN   | accepting rows 2.., one column out per pixel
module line_buffer_ctrl
    import line_buffer_pkg::*;
#(
    parameter int WIDTH_P       = 8,
    parameter int LINE_WIDTH_P  = 640,
    parameter int LINE_HEIGHT_P = 480
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 clear_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH_P-1:0]   data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [3*WIDTH_P-1:0] col_o,
    output logic                 eol_o,
    output logic                 eof_o
);

    localparam int XW_C = x_width(LINE_WIDTH_P);
    localparam int YW_C = y_width(LINE_HEIGHT_P);
    localparam logic [XW_C-1:0] X_LAST_C = XW_C'(LINE_WIDTH_P - 1);
    localparam logic [YW_C-1:0] Y_LAST_C = YW_C'(LINE_HEIGHT_P - 1);

    state_e             state_r, state_n;
    logic [XW_C-1:0]    x_r;
    logic [YW_C-1:0]    y_r;
    logic               s1_valid_r, s1_emit_r;
    logic [WIDTH_P-1:0] s1_pix_r;
    logic [XW_C-1:0]    s1_x_r;
    logic [YW_C-1:0]    s1_y_r;
    logic [WIDTH_P-1:0] ram0_rd, ram1_rd;
    logic               accept, retire, ram_we;

    // Prime-row pixels never wait on the downstream consumer.
    assign retire  = s1_valid_r && (!s1_emit_r || ready_i);
    assign ready_o = !clear_i && (!s1_valid_r || retire);
    assign accept  = valid_i && ready_o;
    assign ram_we  = retire && !clear_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= FILL0;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        if (clear_i) begin
            state_n = FILL0;
        end else if (accept && (x_r == X_LAST_C)) begin
            if (y_r == Y_LAST_C) begin
                state_n = FILL0;
            end else if (y_r == '0) begin
                state_n = FILL1;
            end else begin
                state_n = RUN;
            end
        end
    end

    always_comb begin
        valid_o = s1_valid_r && s1_emit_r;
        eol_o   = s1_valid_r && s1_emit_r && (s1_x_r == X_LAST_C);
        eof_o   = s1_valid_r && s1_emit_r && (s1_x_r == X_LAST_C) && (s1_y_r == Y_LAST_C);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            x_r <= '0;
            y_r <= '0;
        end else if (clear_i) begin
            x_r <= '0;
            y_r <= '0;
        end else if (accept) begin
            if (x_r == X_LAST_C) begin
                x_r <= '0;
                y_r <= (y_r == Y_LAST_C) ? '0 : y_r + YW_C'(1);
            end else begin
                x_r <= x_r + XW_C'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_valid_r <= 1'b0;
            s1_emit_r  <= 1'b0;
            s1_pix_r   <= '0;
            s1_x_r     <= '0;
            s1_y_r     <= '0;
        end else if (clear_i) begin
            s1_valid_r <= 1'b0;
        end else if (accept) begin
            s1_valid_r <= 1'b1;
            s1_emit_r  <= (state_r == RUN);
            s1_pix_r   <= data_i;
            s1_x_r     <= x_r;
            s1_y_r     <= y_r;
        end else if (retire) begin
            s1_valid_r <= 1'b0;
        end
    end

    // RAM0 keeps row y-1; on retire its old word shifts down into RAM1 (row y-2).
    async_ram_1r1w #(.WIDTH_P(WIDTH_P), .DEPTH_P(LINE_WIDTH_P), .ADDR_W_P(XW_C)) u_ram0 (
        .wr_clk_i (clk_i),
        .wr_rstn_i(rstn_i),
        .wr_en_i  (ram_we),
        .wr_addr_i(s1_x_r),
        .wr_data_i(s1_pix_r),
        .rd_clk_i (clk_i),
        .rd_rstn_i(rstn_i),
        .rd_en_i  (accept),
        .rd_addr_i(x_r),
        .rd_data_o(ram0_rd)
    );

    async_ram_1r1w #(.WIDTH_P(WIDTH_P), .DEPTH_P(LINE_WIDTH_P), .ADDR_W_P(XW_C)) u_ram1 (
        .wr_clk_i (clk_i),
        .wr_rstn_i(rstn_i),
        .wr_en_i  (ram_we),
        .wr_addr_i(s1_x_r),
        .wr_data_i(ram0_rd),
        .rd_clk_i (clk_i),
        .rd_rstn_i(rstn_i),
        .rd_en_i  (accept),
        .rd_addr_i(x_r),
        .rd_data_o(ram1_rd)
    );

    assign col_o = {ram1_rd, ram0_rd, s1_pix_r};

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl on a 4x4 frame against a frame-array reference model.
module tb_line_buffer_ctrl;

    localparam int W  = 8;
    localparam int LW = 4;
    localparam int LH = 4;

    logic          clk_i   = 1'b0;
    logic          rstn_i  = 1'b0;
    logic          clear_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [W-1:0]  data_i  = '0;
    logic          ready_o, valid_o, eol_o, eof_o;
    logic [3*W-1:0] col_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3*W-1:0] col;
        logic           eol;
        logic           eof;
        int             cyc;
    } col_t;

    col_t         exp_q[$];
    col_t         obs_q[$];
    logic [W-1:0] rows [LH][LW];
    int           mx = 0, my = 0;
    int           cyc_cnt = 0;
    int           stall_err = 0;
    logic         prev_hold = 1'b0;
    logic [3*W-1:0] prev_col = '0;

    line_buffer_ctrl #(.WIDTH_P(W), .LINE_WIDTH_P(LW), .LINE_HEIGHT_P(LH)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clear_i(clear_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .col_o  (col_o),
        .eol_o  (eol_o),
        .eof_o  (eof_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc_cnt++;

    // Records every delivered column and counts hold violations during stalls.
    always @(negedge clk_i) begin
        if (rstn_i && prev_hold && (valid_o !== 1'b1 || col_o !== prev_col)) stall_err++;
        if (rstn_i && valid_o === 1'b1 && ready_i) obs_q.push_back('{col_o, eol_o, eof_o, cyc_cnt});
        prev_hold = rstn_i && valid_o && !ready_i && !clear_i;
        prev_col  = col_o;
    end

    function automatic void mdl_accept(input logic [W-1:0] d);
        col_t e;
        rows[my][mx] = d;
        if (my >= 2) begin
            e.col = {rows[my-2][mx], rows[my-1][mx], d};
            e.eol = (mx == LW-1);
            e.eof = (mx == LW-1) && (my == LH-1);
            e.cyc = cyc_cnt;
            exp_q.push_back(e);
        end
        mx++;
        if (mx == LW) begin
            mx = 0;
            my = (my + 1) % LH;
        end
    endfunction

    function automatic void mdl_clear();
        mx = 0;
        my = 0;
    endfunction

    function automatic logic [W-1:0] next_pix(input bit rnd_data);
        return rnd_data ? W'($urandom) : W'(16*my + mx);
    endfunction

    task automatic stream(input int n, input int vpct, input int rpct, input bit rnd_data, input string tag);
        int           acc = 0;
        int           budget = 0;
        bit           pend = 0;
        logic [W-1:0] pd = '0;
        while (acc < n && budget < 4000) begin
            @(posedge clk_i); #1;
            if (!pend && ($urandom_range(99) < vpct)) begin
                pend = 1;
                pd   = next_pix(rnd_data);
            end
            valid_i = pend;
            data_i  = pd;
            ready_i = ($urandom_range(99) < rpct);
            @(negedge clk_i);
            if (valid_i && ready_o) begin
                mdl_accept(data_i);
                pend = 0;
                acc++;
            end
            budget++;
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        checks++;
        if (acc != n) begin
            failures++;
            $display("FAIL %s accept_budget: accepted %0d want %0d", tag, acc, n);
        end
    endtask

    task automatic drain();
        valid_i = 1'b0;
        ready_i = 1'b1;
        clear_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        checks++;
        if ({valid_o, ready_o, eol_o, eof_o} !== 4'b0100 || col_o !== '0) begin
            failures++;
            $display("FAIL reset_hold: got v=%b r=%b eol=%b eof=%b col=%h want v=0 r=1 eol=0 eof=0 col=0",
                     valid_o, ready_o, eol_o, eof_o, col_o);
        end
        @(posedge clk_i); #1;
        rstn_i  = 1'b1;
        ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({valid_o, ready_o, eol_o, eof_o} !== 4'b0100 || col_o !== '0) begin
            failures++;
            $display("FAIL reset_release: got v=%b r=%b eol=%b eof=%b col=%h want v=0 r=1 eol=0 eof=0 col=0",
                     valid_o, ready_o, eol_o, eof_o, col_o);
        end
    endtask

    task automatic test_full_rate();
        int n_eol = 0;
        int n_eof = 0;
        obs_q.delete(); exp_q.delete();
        stream(8, 100, 100, 0, "full_rate");
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL full_rate prime_silent: got %0d outputs want 0", obs_q.size());
        end
        stream(8, 100, 100, 0, "full_rate");
        drain();
        checks++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            failures++;
            $display("FAIL full_rate count: got %0d want 8 (model %0d)", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].col !== exp_q[i].col || obs_q[i].eol !== exp_q[i].eol ||
                obs_q[i].eof !== exp_q[i].eof || obs_q[i].cyc != exp_q[i].cyc + 1) begin
                failures++;
                $display("FAIL full_rate col[%0d]: got %h eol=%b eof=%b cyc=%0d want %h eol=%b eof=%b cyc=%0d",
                         i, obs_q[i].col, obs_q[i].eol, obs_q[i].eof, obs_q[i].cyc,
                         exp_q[i].col, exp_q[i].eol, exp_q[i].eof, exp_q[i].cyc + 1);
            end
            if (obs_q[i].eol === 1'b1) n_eol++;
            if (obs_q[i].eof === 1'b1) n_eof++;
        end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0].col !== 24'h001020) begin
                failures++;
                $display("FAIL full_rate first_col: got %h want 001020", obs_q[0].col);
            end
        end
        checks++;
        if (n_eol != 2 || n_eof != 1) begin
            failures++;
            $display("FAIL full_rate flag_counts: got eol=%0d eof=%0d want eol=2 eof=1", n_eol, n_eof);
        end
        if (obs_q.size() == 8) begin
            checks++;
            if (obs_q[7].col !== 24'h132333 || obs_q[7].eof !== 1'b1 || obs_q[3].col !== 24'h031323 || obs_q[3].eol !== 1'b1) begin
                failures++;
                $display("FAIL full_rate eol_eof_cols: got [3]=%h eol=%b [7]=%h eof=%b want 031323/1 132333/1",
                         obs_q[3].col, obs_q[3].eol, obs_q[7].col, obs_q[7].eof);
            end
        end
    endtask

    task automatic test_backpressure();
        obs_q.delete(); exp_q.delete();
        stall_err = 0;
        stream(9, 100, 100, 0, "backpressure");
        @(posedge clk_i); #1;
        valid_i = 1'b1; data_i = next_pix(0); ready_i = 1'b1;
        @(negedge clk_i);
        if (ready_o) mdl_accept(data_i);
        @(posedge clk_i); #1;
        data_i = next_pix(0); ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (valid_o !== 1'b1 || col_o !== 24'h011121 || ready_o !== 1'b0) begin
                failures++;
                $display("FAIL backpressure stall[%0d]: got v=%b col=%h r=%b want v=1 col=011121 r=0",
                         i, valid_o, col_o, ready_o);
            end
            if (i < 2) begin
                @(posedge clk_i); #1;
            end
        end
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL backpressure release_ready: got %b want 1", ready_o);
        end
        if (ready_o) mdl_accept(data_i);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b1 || col_o !== 24'h021222) begin
            failures++;
            $display("FAIL backpressure next_col: got v=%b col=%h want v=1 col=021222", valid_o, col_o);
        end
        stream(5, 100, 100, 0, "backpressure");
        drain();
        checks++;
        if (obs_q.size() != exp_q.size() || stall_err != 0) begin
            failures++;
            $display("FAIL backpressure count: got %0d outputs, %0d hold errors want %0d, 0",
                     obs_q.size(), stall_err, exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].col !== exp_q[i].col || obs_q[i].eol !== exp_q[i].eol || obs_q[i].eof !== exp_q[i].eof) begin
                failures++;
                $display("FAIL backpressure col[%0d]: got %h/%b/%b want %h/%b/%b", i,
                         obs_q[i].col, obs_q[i].eol, obs_q[i].eof, exp_q[i].col, exp_q[i].eol, exp_q[i].eof);
            end
        end
    endtask

    task automatic test_bubbles();
        obs_q.delete(); exp_q.delete();
        stream(16, 45, 100, 0, "bubbles");
        drain();
        checks++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            failures++;
            $display("FAIL bubbles count: got %0d want 8 (model %0d)", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].col !== exp_q[i].col || obs_q[i].eol !== exp_q[i].eol ||
                obs_q[i].eof !== exp_q[i].eof || obs_q[i].cyc != exp_q[i].cyc + 1) begin
                failures++;
                $display("FAIL bubbles col[%0d]: got %h/%b/%b cyc=%0d want %h/%b/%b cyc=%0d", i,
                         obs_q[i].col, obs_q[i].eol, obs_q[i].eof, obs_q[i].cyc,
                         exp_q[i].col, exp_q[i].eol, exp_q[i].eof, exp_q[i].cyc + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_q.delete(); exp_q.delete();
        stream(32, 100, 100, 0, "back_to_back");
        drain();
        checks++;
        if (obs_q.size() != 16 || exp_q.size() != 16) begin
            failures++;
            $display("FAIL back_to_back count: got %0d want 16 (model %0d)", obs_q.size(), exp_q.size());
        end
        if (obs_q.size() > 8) begin
            checks++;
            if (obs_q[8].col !== 24'h001020 || obs_q[8].cyc != obs_q[7].cyc + 9) begin
                failures++;
                $display("FAIL back_to_back second_first: got %h gap=%0d want 001020 gap=9",
                         obs_q[8].col, obs_q[8].cyc - obs_q[7].cyc);
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].col !== exp_q[i].col || obs_q[i].eol !== exp_q[i].eol || obs_q[i].eof !== exp_q[i].eof) begin
                failures++;
                $display("FAIL back_to_back col[%0d]: got %h/%b/%b want %h/%b/%b", i,
                         obs_q[i].col, obs_q[i].eol, obs_q[i].eof, exp_q[i].col, exp_q[i].eol, exp_q[i].eof);
            end
        end
    endtask

    task automatic test_clear();
        int n_pre;
        obs_q.delete(); exp_q.delete();
        stream(9, 100, 100, 0, "clear");
        @(posedge clk_i); #1;
        valid_i = 1'b1; data_i = next_pix(0); ready_i = 1'b1;
        @(negedge clk_i);
        if (ready_o) mdl_accept(data_i);
        @(posedge clk_i); #1;
        valid_i = 1'b0; ready_i = 1'b0; clear_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
            failures++;
            $display("FAIL clear during: got v=%b r=%b want v=1 r=0", valid_o, ready_o);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        mdl_clear();
        @(posedge clk_i); #1;
        clear_i = 1'b0; ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            failures++;
            $display("FAIL clear after: got v=%b r=%b want v=0 r=1", valid_o, ready_o);
        end
        n_pre = obs_q.size();
        stream(16, 100, 100, 0, "clear");
        drain();
        checks++;
        if (obs_q.size() - n_pre != 8 || obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL clear count: got %0d new of %0d total want 8 of %0d", obs_q.size() - n_pre,
                     obs_q.size(), exp_q.size());
        end
        if (obs_q.size() > n_pre) begin
            checks++;
            if (obs_q[n_pre].col !== 24'h001020) begin
                failures++;
                $display("FAIL clear fresh_first: got %h want 001020", obs_q[n_pre].col);
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].col !== exp_q[i].col || obs_q[i].eol !== exp_q[i].eol || obs_q[i].eof !== exp_q[i].eof) begin
                failures++;
                $display("FAIL clear col[%0d]: got %h/%b/%b want %h/%b/%b", i,
                         obs_q[i].col, obs_q[i].eol, obs_q[i].eof, exp_q[i].col, exp_q[i].eol, exp_q[i].eof);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_q.delete(); exp_q.delete();
        stream(6, 100, 100, 0, "reset_mid");
        rstn_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || col_o !== '0) begin
            failures++;
            $display("FAIL reset_mid during: got v=%b r=%b col=%h want v=0 r=1 col=0", valid_o, ready_o, col_o);
        end
        mdl_clear();
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        stream(16, 100, 100, 0, "reset_mid");
        drain();
        checks++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            failures++;
            $display("FAIL reset_mid count: got %0d want 8 (model %0d)", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].col !== exp_q[i].col || obs_q[i].eol !== exp_q[i].eol || obs_q[i].eof !== exp_q[i].eof) begin
                failures++;
                $display("FAIL reset_mid col[%0d]: got %h/%b/%b want %h/%b/%b", i,
                         obs_q[i].col, obs_q[i].eol, obs_q[i].eof, exp_q[i].col, exp_q[i].eol, exp_q[i].eof);
            end
        end
    endtask

    task automatic test_random();
        obs_q.delete(); exp_q.delete();
        stall_err = 0;
        stream(48, 70, 55, 1, "random");
        drain();
        checks++;
        if (obs_q.size() != 24 || exp_q.size() != 24 || stall_err != 0) begin
            failures++;
            $display("FAIL random count: got %0d outputs, %0d hold errors want 24, 0 (model %0d)",
                     obs_q.size(), stall_err, exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].col !== exp_q[i].col || obs_q[i].eol !== exp_q[i].eol || obs_q[i].eof !== exp_q[i].eof) begin
                failures++;
                $display("FAIL random col[%0d]: got %h/%b/%b want %h/%b/%b", i,
                         obs_q[i].col, obs_q[i].eol, obs_q[i].eof, exp_q[i].col, exp_q[i].eol, exp_q[i].eof);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_bubbles();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Streaming controller that sequences two single-clock-domain 1R1W RAMs as row-delay line buffers for the Sobel datapath. It accepts a raster pixel stream over ready/valid and emits, per input pixel, a vertical 3-pixel column {row y-2, row y-1, row y} for the downstream 3x3 window shifter. It tracks column and row position, suppresses output during the two-row prime phase, and flags end-of-line and end-of-frame.

## Interface
- WIDTH_P, 8, pixel width in bits
- LINE_WIDTH_P, 640, pixels per row; also the depth of each RAM; must be ≥ 2
- LINE_HEIGHT_P, 480, rows per frame; must be ≥ 3
- clk_i  in  1  single clock for the block and both RAMs
- rstn_i  in  1  reset; asynchronous assert, active-low
- clear_i  in  1  synchronous abort: drop in-flight pixel, return to frame start
- valid_i  in  1  input pixel valid
- ready_o  out  1  input pixel accepted when valid_i && ready_o
- data_i  in  WIDTH_P  input pixel, raster order
- valid_o  out  1  output column valid
- ready_i  in  1  downstream ready
- col_o  out  3*WIDTH_P  {row y-2, row y-1, row y}, MSB slice is oldest
- eol_o  out  1  output column is last of its row (x = LINE_WIDTH_P-1)
- eof_o  out  1  output column is last of the frame (eol_o and y = LINE_HEIGHT_P-1)

## Operation
- Position counters: x in [0, LINE_WIDTH_P-1], y in [0, LINE_HEIGHT_P-1]; both advance on input accept; x wraps to 0 and increments y; y wraps to 0 after the last pixel of the frame.
- FSM on y of the accepted pixel: FILL0 (y=0) → FILL1 (y=1) → RUN (y ≥ 2) → FILL0 after the frame's last pixel accepts.
- Stage s1 (one entry): holds pixel, x, y, emit flag (state was RUN at accept).
- Accept: rd_en to both RAMs with rd_addr = x; s1 loads pixel/x/y/emit.
- RAM0 holds row y-1, RAM1 holds row y-2. col_o = {RAM1 rd_data, RAM0 rd_data, s1 pixel}.
- Retire s1 when s1_valid && (!emit || ready_i). On retire: write RAM0[s1.x] ← s1 pixel, RAM1[s1.x] ← RAM0 rd_data.
- valid_o = s1_valid && emit. eol_o/eof_o derived from s1.x/s1.y, gated by valid_o.
- ready_o = !s1_valid || retire (accept and retire may occur in the same cycle).
- rd_en only on accept, so RAM read data holds stable through downstream stalls.
- clear_i: s1_valid ← 0, x,y ← 0, state ← FILL0, no RAM write that cycle, ready_o forced 0 that cycle. RAM contents are not cleared; the prime phase overwrites them.
- Reset mid-frame behaves as clear_i.

## Timing
- Latency: pixel accepted in cycle t appears on col_o with valid_o in t+1 (RUN only).
- Throughput: one pixel per cycle with ready_i held high.
- Same-cycle write (s1.x) and read (x) addresses always differ, including wrap from LINE_WIDTH_P-1 to 0, since LINE_WIDTH_P ≥ 2. There is no read-during-write hazard.
- Reset values: valid_o 0, eol_o 0, eof_o 0, col_o 0, ready_o 1 (combinational, s1 empty); x,y 0; state FILL0.
- valid_o held with col_o stable until ready_i; valid_o never drops without a handshake except on clear_i or reset.
- Prime rows retire unconditionally; ready_i is ignored during FILL0/FILL1.

## Structure
- Shared package line_buffer_pkg: state_e enum {FILL0, FILL1, RUN}; the counter-width localparams $clog2(LINE_WIDTH_P) and $clog2(LINE_HEIGHT_P) as package functions.
- Two instances of async_ram_1r1w (WIDTH_P, DEPTH_P = LINE_WIDTH_P), with both clocks tied to clk_i and both resets tied to rstn_i.
- Control (counters, FSM, s1) stays in the top module; no further sub-module.

## Test plan
- Use WIDTH_P=8, LINE_WIDTH_P=4, LINE_HEIGHT_P=4, pixel value = 16*y + x.
- Reset: after rstn_i release, valid_o=0, ready_o=1, col_o=0, no output for the first 8 accepted pixels.
- Full-rate frame: 16 pixels back to back with ready_i=1 gives 8 outputs. The first col_o is {0x00,0x10,0x20}, 1 cycle after pixel 0x20. eol_o is set on 0x23 and 0x33; eof_o only on {0x13,0x23,0x33}.
- Backpressure: ready_i=0 for 3 cycles while col_o={0x01,0x11,0x21}. The column holds stable, ready_o=0, x does not advance. The next column is {0x02,0x12,0x22}.
- Bubbles: random valid_i gaps across a row wrap give identical columns to the full-rate run.
- Back-to-back frames: the second frame's first output is {0x00,0x10,0x20} again, with no output during its rows 0–1.
- clear_i asserted mid-row 2 with s1 full: valid_o drops next cycle. The following 8 pixels produce no output, then the columns match a fresh frame.
